// File: rtl/spi_xfer_sequencer_if.sv
// rtl/spi_xfer_sequencer_if.sv - host byte stream, RX return and SPI driver signal bundle
interface spi_xfer_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] spi_data;
    logic              spi_start;
    logic              spi_en;
    logic [DATA_W-1:0] spi_rdata;

    modport slave (
        input  tx_data, tx_valid, rx_ready, spi_en, spi_rdata,
        output tx_ready, rx_data, rx_valid, spi_data, spi_start
    );

    modport master (
        output tx_data, tx_valid, rx_ready, spi_en, spi_rdata,
        input  tx_ready, rx_data, rx_valid, spi_data, spi_start
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - TX byte FIFO feeding one SPI driver transfer at a time, RX byte return
module spi_xfer_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    spi_xfer_sequencer_if.slave    bus,
    input  logic                   i_clear_err,
    output logic [$clog2(DEPTH):0] o_fifo_level,
    output logic                   o_busy,
    output logic                   o_timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_EN,
        S_WAIT_DONE,
        S_ABORT
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [DATA_W-1:0] r_spi_data;
    logic              r_spi_start;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_timeout_err;

    logic w_tx_ready;
    logic w_push;
    logic w_pop;
    logic w_timer_done;

    assign w_tx_ready   = (r_level != LW'(DEPTH));
    assign w_push       = bus.tx_valid && w_tx_ready;
    // Launch only once the previous RX byte has been taken, so RX can never overflow.
    assign w_pop        = (r_state == S_IDLE) && (r_level != '0) && !r_rx_valid;
    assign w_timer_done = (r_timer == TW'(TIMEOUT - 1));

    assign bus.tx_ready   = w_tx_ready;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.spi_data   = r_spi_data;
    assign bus.spi_start  = r_spi_start;
    assign o_fifo_level   = r_level;
    assign o_busy         = (r_state != S_IDLE);
    assign o_timeout_err  = r_timeout_err;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_spi_data    <= '0;
            r_spi_start   <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_spi_start <= 1'b0;
            if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (r_state == S_ABORT) begin
                r_timeout_err <= 1'b1;
            end else if (i_clear_err) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_spi_data <= r_mem[r_rd_ptr];
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    // Registered pulse: high for the single cycle following START.
                    r_spi_start <= !bus.spi_en;
                    r_timer     <= '0;
                    r_state     <= S_WAIT_EN;
                end
                S_WAIT_EN: begin
                    if (bus.spi_en) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (w_timer_done) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.spi_en) begin
                        r_rx_data  <= bus.spi_rdata;
                        r_rx_valid <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (w_timer_done) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - scoreboard bench for spi_xfer_sequencer with a behavioural SPI driver
module tb_spi_xfer_sequencer;
    localparam int DEPTH   = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst_n;
    logic       clear_err;
    logic [3:0] fifo_level;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    logic [7:0] exp_spi[$];
    logic [7:0] exp_rx[$];

    int         drv_len = 10;
    int         drv_ignore = 0;
    bit         drv_fixed = 0;
    logic [7:0] drv_fixed_val = 8'h00;
    bit         drv_busy = 0;

    spi_xfer_sequencer_if #(.DATA_W(DATA_W)) sif ();

    spi_xfer_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .bus           (sif),
        .i_clear_err   (clear_err),
        .o_fifo_level  (fifo_level),
        .o_busy        (busy),
        .o_timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver model: sees the launch pulse, raises enable two cycles later, holds it drv_len cycles.
    initial begin
        sif.spi_en    = 1'b0;
        sif.spi_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (sif.spi_start && rst_n) begin
                if (drv_ignore > 0) begin
                    drv_ignore--;
                end else begin
                    drv_busy = 1;
                    sif.spi_rdata = drv_fixed ? drv_fixed_val : sif.spi_data;
                    repeat (2) @(posedge clk);
                    #1 sif.spi_en = 1'b1;
                    repeat (drv_len) @(posedge clk);
                    #1 sif.spi_en = 1'b0;
                    drv_busy = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sif.spi_start) begin
                    start_cnt++;
                    checks++;
                    if (sif.spi_en) begin
                        errors++;
                        $display("FAIL start_while_en: spi_en=%0b required 0", sif.spi_en);
                    end else if (exp_spi.size() == 0) begin
                        errors++;
                        $display("FAIL spi_data_unexpected: got %02h, no launch expected", sif.spi_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_spi.pop_front();
                        if (sif.spi_data !== e) begin
                            errors++;
                            $display("FAIL spi_data: got %02h required %02h", sif.spi_data, e);
                        end
                    end
                end
                if (sif.rx_valid && sif.rx_ready) begin
                    checks++;
                    if (exp_rx.size() == 0) begin
                        errors++;
                        $display("FAIL rx_unexpected: got %02h, no byte expected", sif.rx_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_rx.pop_front();
                        if (sif.rx_data !== e) begin
                            errors++;
                            $display("FAIL rx_data: got %02h required %02h", sif.rx_data, e);
                        end
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic [7:0] rx_exp, input bit dropped);
        bit acc;
        sif.tx_data  = d;
        sif.tx_valid = 1'b1;
        acc = sif.tx_ready;
        @(posedge clk);
        #1;
        sif.tx_valid = 1'b0;
        if (acc) begin
            exp_spi.push_back(d);
            if (!dropped) exp_rx.push_back(rx_exp);
        end
    endtask

    task automatic wait_rx_valid(input string name);
        int n;
        n = 0;
        while (!sif.rx_valid && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!sif.rx_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: rx_valid=0 required 1 within 500 cycles", name);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_rx.size() != 0 || busy || fifo_level != 0 || drv_busy || sif.rx_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_rx.size() != 0 || exp_spi.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain: rx_left=%0d spi_left=%0d busy=%0b required 0 0 0",
                     name, exp_rx.size(), exp_spi.size(), busy);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (fifo_level !== 4'd0 || sif.tx_ready !== 1'b1 || sif.rx_valid !== 1'b0 ||
            sif.rx_data !== 8'h00 || sif.spi_data !== 8'h00 || sif.spi_start !== 1'b0 ||
            busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: level=%0d tx_ready=%0b rx_valid=%0b rx_data=%02h spi_data=%02h start=%0b busy=%0b err=%0b required 0 1 0 00 00 0 0 0",
                     name, fifo_level, sif.tx_ready, sif.rx_valid, sif.rx_data, sif.spi_data,
                     sif.spi_start, busy, timeout_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        drv_fixed     = 1;
        drv_fixed_val = 8'h3C;
        drv_len       = 10;
        sif.rx_ready  = 1'b1;
        push_byte(8'hA5, 8'h3C, 0);
        @(posedge clk);
        #1;
        checks++;
        if (sif.spi_start !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: spi_start=%0b required 0 one cycle after push", sif.spi_start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sif.spi_start !== 1'b1 || sif.spi_data !== 8'hA5) begin
            errors++;
            $display("FAIL latency: spi_start=%0b spi_data=%02h required 1 a5", sif.spi_start, sif.spi_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sif.spi_start !== 1'b0) begin
            errors++;
            $display("FAIL start_width: spi_start=%0b required 0", sif.spi_start);
        end
        wait_drain("single");
        drv_fixed = 0;
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = start_cnt;
        drv_len      = 3;
        sif.rx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push_byte(8'(i), 8'(i), 0);
        end
        wait_drain("back_to_back");
        checks++;
        if (start_cnt - s0 != 8) begin
            errors++;
            $display("FAIL b2b_count: starts=%0d required 8", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        int n;
        drv_len      = 3;
        sif.rx_ready = 1'b0;
        s0 = start_cnt;
        push_byte(8'h31, 8'h31, 0);
        push_byte(8'h32, 8'h32, 0);
        push_byte(8'h33, 8'h33, 0);
        wait_rx_valid("bp_first");
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (start_cnt - s0 != 1 || fifo_level !== 4'd2) begin
            errors++;
            $display("FAIL bp_stall: starts=%0d level=%0d required 1 2", start_cnt - s0, fifo_level);
        end
        sif.rx_ready = 1'b1;
        n = 0;
        while (start_cnt - s0 < 2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (start_cnt - s0 < 2) begin
            errors++;
            $display("FAIL bp_release: starts=%0d required 2 within 20 cycles", start_cnt - s0);
        end
        wait_drain("backpressure");
    endtask

    task automatic test_timeout();
        int n;
        drv_ignore   = 1;
        drv_len      = 3;
        sif.rx_ready = 1'b1;
        push_byte(8'h11, 8'h00, 1);
        n = 0;
        while (!sif.spi_start && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        push_byte(8'h22, 8'h22, 0);
        n = 1;
        while (!timeout_err && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != TIMEOUT + 1 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cycles: err=%0b after %0d cycles required 1 after %0d", timeout_err, n, TIMEOUT + 1);
        end
        wait_drain("timeout");
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%0b required 1", timeout_err);
        end
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_err: err=%0b required 0", timeout_err);
        end
    endtask

    task automatic test_fifo_bounds();
        drv_len      = 2;
        sif.rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'h40 + 8'(i), 8'h40 + 8'(i), 0);
        end
        wait_rx_valid("fb_first");
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL level_pre: level=%0d required 3", fifo_level);
        end
        sif.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.rx_ready = 1'b0;
        push_byte(8'h50, 8'h50, 0);
        checks++;
        if (fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL push_pop_same: level=%0d required 3", fifo_level);
        end
        wait_rx_valid("fb_second");
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h60 + 8'(i), 8'h60 + 8'(i), 0);
        end
        checks++;
        if (fifo_level !== 4'd8 || sif.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: level=%0d tx_ready=%0b required 8 0", fifo_level, sif.tx_ready);
        end
        push_byte(8'hEE, 8'hEE, 0);
        checks++;
        if (fifo_level !== 4'd8) begin
            errors++;
            $display("FAIL full_no_push: level=%0d required 8", fifo_level);
        end
        sif.rx_ready = 1'b1;
        wait_drain("fifo_bounds");
    endtask

    task automatic test_reset_mid();
        int s0;
        int n;
        drv_len      = 30;
        sif.rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h70 + 8'(i), 8'h70 + 8'(i), 0);
        end
        n = 0;
        while (!sif.spi_en && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (fifo_level !== 4'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: level=%0d busy=%0b required 4 1", fifo_level, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        exp_spi.delete();
        exp_rx.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        s0 = start_cnt;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (start_cnt != s0 || busy !== 1'b0 || drv_busy) begin
            errors++;
            $display("FAIL post_reset_idle: starts=%0d busy=%0b required 0 0", start_cnt - s0, busy);
        end
        drv_len = 3;
        push_byte(8'h99, 8'h99, 0);
        wait_drain("reset_mid");
    endtask

    initial begin
        rst_n        = 1'b0;
        clear_err    = 1'b0;
        sif.tx_data  = 8'h00;
        sif.tx_valid = 1'b0;
        sif.rx_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_fifo_bounds();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
